// File: rtl/right_shift_of_n_by_variable_pipelined.sv
// Pipelined right barrel shifter: one log2 stage per register slice, valid/ready with global stall.
// Define RIGHT_SHIFT_OF_N_BY_VARIABLE_ARITH_EN to enable per-transaction sign fill via arith.
module right_shift_of_n_by_variable_pipelined #(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  arg,
    input  logic [SW-1:0] shamt,
    input  logic          arith,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res
);

    localparam int unsigned L    = SW;
    localparam int unsigned RemW = (SW > 1) ? SW - 1 : 1;
    localparam int unsigned RegL = (L > 1) ? L - 1 : 1;

    logic         v_q [L];
    logic         v_d [L];
    logic [N-1:0] d_q [L];
    logic [N-1:0] d_d [L];

    // Stage k carries shamt[SW-1:1]; the next stage consumes bit k of the original amount.
    logic [RemW-1:0] rem_q [RegL];
    logic [RemW-1:0] rem_d [RegL];

    logic fill0;
    logic adv;

`ifdef RIGHT_SHIFT_OF_N_BY_VARIABLE_ARITH_EN
    logic fill_q [RegL];
    logic fill_d [RegL];
    assign fill0 = arith & arg[N-1];
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign fill0        = 1'b0;
`endif

    assign adv     = !v_q[L-1] || res_rdy;
    assign arg_rdy = adv;
    assign res_vld = v_q[L-1];
    assign res     = d_q[L-1];

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int unsigned Sh = 1 << k;
        logic [N-1:0] src;
        logic         sel;
        logic         fill;

        if (k == 0) begin : g_first
            assign src    = arg;
            assign sel    = shamt[0];
            assign fill   = fill0;
            assign v_d[0] = arg_vld;
        end else begin : g_next
            assign src    = d_q[k-1];
            assign sel    = rem_q[k-1][k-1];
`ifdef RIGHT_SHIFT_OF_N_BY_VARIABLE_ARITH_EN
            assign fill   = fill_q[k-1];
`else
            assign fill   = 1'b0;
`endif
            assign v_d[k] = v_q[k-1];
        end

        assign d_d[k] = sel ? {{Sh{fill}}, src[N-1:Sh]} : src;

        if (k < L - 1) begin : g_carry
            if (k == 0) begin : g_carry_first
                assign rem_d[0]  = shamt[SW-1:1];
`ifdef RIGHT_SHIFT_OF_N_BY_VARIABLE_ARITH_EN
                assign fill_d[0] = fill0;
`endif
            end else begin : g_carry_next
                assign rem_d[k]  = rem_q[k-1];
`ifdef RIGHT_SHIFT_OF_N_BY_VARIABLE_ARITH_EN
                assign fill_d[k] = fill_q[k-1];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                v_q[k] <= 1'b0;
                d_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < L; k++) begin
                v_q[k] <= v_d[k];
                d_q[k] <= d_d[k];
            end
        end
    end

    // Side-band shift/fill bits only matter alongside a valid stage, so they need no reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < L - 1; k++) begin
                rem_q[k]  <= rem_d[k];
`ifdef RIGHT_SHIFT_OF_N_BY_VARIABLE_ARITH_EN
                fill_q[k] <= fill_d[k];
`endif
            end
        end
    end

endmodule

// File: tb/tb_right_shift_of_n_by_variable_pipelined.sv
// Self-checking bench: vector table plus directed latency, streaming, stall and reset sequences.
module tb_right_shift_of_n_by_variable_pipelined;

    localparam int L = 3;
`ifdef RIGHT_SHIFT_OF_N_BY_VARIABLE_ARITH_EN
    localparam bit ArithEn = 1'b1;
`else
    localparam bit ArithEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arg_vld = 1'b0;
    logic       arg_rdy;
    logic [7:0] arg = '0;
    logic [2:0] shamt = '0;
    logic       arith = 1'b0;
    logic       res_vld;
    logic       res_rdy = 1'b1;
    logic [7:0] res;
    logic [7:0] cur_exp = '0;

    always #5 clk = ~clk;

    right_shift_of_n_by_variable_pipelined #(.N(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld),
        .arg_rdy (arg_rdy),
        .arg     (arg),
        .shamt   (shamt),
        .arith   (arith),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res     (res)
    );

    typedef struct {
        logic [7:0] a;
        logic [2:0] s;
        logic       ar;
        logic [7:0] exp_l;
        logic [7:0] exp_a;
    } vec_t;

    vec_t       tbl [12];
    int         tests = 0;
    int         fails = 0;
    int         pops  = 0;
    logic [7:0] exp_q [$];

    function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] s, input logic ar);
        if (ar && ArithEn) return $signed(a) >>> s;
        return a >> s;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (res_vld && res_rdy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got res=%0h, expected no result", res);
                end else begin
                    pops++;
                    check("res_data", {24'd0, res}, {24'd0, exp_q.pop_front()});
                end
            end
            if (arg_vld && arg_rdy) exp_q.push_back(cur_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic drive(input logic [7:0] a, input logic [2:0] s, input logic ar,
                         input logic [7:0] e);
        arg = a; shamt = s; arith = ar; cur_exp = e; arg_vld = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         c;
        int         run;
        int         maxrun;
        int         nhi;
        logic [5:0] pat;
        logic [7:0] bp_a [4];
        logic [2:0] bp_s [4];
        logic       bp_r [4];

        tbl[0]  = '{8'hB0, 3'd3, 1'b0, 8'h16, 8'h16};
        tbl[1]  = '{8'hB0, 3'd3, 1'b1, 8'h16, 8'hF6};
        tbl[2]  = '{8'h80, 3'd7, 1'b1, 8'h01, 8'hFF};
        tbl[3]  = '{8'hA5, 3'd0, 1'b0, 8'hA5, 8'hA5};
        tbl[4]  = '{8'hA5, 3'd7, 1'b0, 8'h01, 8'h01};
        tbl[5]  = '{8'hA5, 3'd0, 1'b1, 8'hA5, 8'hA5};
        tbl[6]  = '{8'hFF, 3'd4, 1'b1, 8'h0F, 8'hFF};
        tbl[7]  = '{8'h7F, 3'd7, 1'b1, 8'h00, 8'h00};
        tbl[8]  = '{8'hC3, 3'd1, 1'b0, 8'h61, 8'h61};
        tbl[9]  = '{8'hC3, 3'd1, 1'b1, 8'h61, 8'hE1};
        tbl[10] = '{8'h96, 3'd2, 1'b1, 8'h25, 8'hE5};
        tbl[11] = '{8'h3C, 3'd5, 1'b0, 8'h01, 8'h01};

        bp_a = '{8'hE7, 8'h5A, 8'h81, 8'h3C};
        bp_s = '{3'd2, 3'd1, 3'd6, 3'd3};
        bp_r = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res_vld", {31'd0, res_vld}, 32'd0);
        check("rst_res", {24'd0, res}, 32'd0);
        check("rst_arg_rdy", {31'd0, arg_rdy}, 32'd1);
        next_cycle();
        rst = 1'b0;

        // Single-transaction latency
        drive(8'hB0, 3'd3, 1'b0, 8'h16);
        next_cycle();
        arg_vld = 1'b0;
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (res_vld) break;
        end
        check("latency", c, L);
        next_cycle();
        @(negedge clk);
        check("single_vld_pulse", {31'd0, res_vld}, 32'd0);
        next_cycle();

        // Vector table, back to back
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].a, tbl[i].s, tbl[i].ar, ArithEn ? tbl[i].exp_a : tbl[i].exp_l);
            next_cycle();
        end
        arg_vld = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_cycle();
        check("table_drain", exp_q.size(), 0);

        // Streaming: 8 consecutive results in order
        run = 0; maxrun = 0; nhi = 0;
        for (int j = 0; j < 14; j++) begin
            if (j < 8) drive(8'(j * 17), 3'(j), j[0], model(8'(j * 17), 3'(j), j[0]));
            else arg_vld = 1'b0;
            @(negedge clk);
            if (res_vld) begin
                run++; nhi++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            next_cycle();
        end
        check("stream_run", maxrun, 8);
        check("stream_count", nhi, 8);

        // Backpressure: fill with res_rdy low, stall 5 cycles, then drain
        res_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(bp_a[j], bp_s[j], bp_r[j], model(bp_a[j], bp_s[j], bp_r[j]));
            @(negedge clk);
            check("bp_fill_rdy", {31'd0, arg_rdy}, 32'd1);
            next_cycle();
        end
        drive(bp_a[3], bp_s[3], bp_r[3], model(bp_a[3], bp_s[3], bp_r[3]));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_arg_rdy", {31'd0, arg_rdy}, 32'd0);
            check("bp_res_vld", {31'd0, res_vld}, 32'd1);
            check("bp_res_hold", {24'd0, res}, {24'd0, model(bp_a[0], bp_s[0], bp_r[0])});
            next_cycle();
        end
        res_rdy = 1'b1;
        arg_vld = 1'b0;
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat = {pat[4:0], res_vld};
            next_cycle();
        end
        check("bp_drain_pattern", {26'd0, pat}, 32'b111000);

        // Reset with a full pipeline in flight
        res_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(8'(8'h91 + j), 3'(j + 1), 1'b1, model(8'(8'h91 + j), 3'(j + 1), 1'b1));
            next_cycle();
        end
        arg_vld = 1'b0;
        @(negedge clk);
        check("rst_prefill_vld", {31'd0, res_vld}, 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_res_vld", {31'd0, res_vld}, 32'd0);
        check("midrst_res", {24'd0, res}, 32'd0);
        check("midrst_arg_rdy", {31'd0, arg_rdy}, 32'd1);
        next_cycle();
        res_rdy = 1'b1;
        nhi = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (res_vld) nhi++;
            next_cycle();
        end
        check("midrst_no_stale", nhi, 0);
        drive(8'hC0, 3'd6, 1'b1, ArithEn ? 8'hFF : 8'h03);
        next_cycle();
        arg_vld = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_cycle();
        check("final_empty", exp_q.size(), 0);
        check("pop_count", pops, 25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
